// File: rtl/mac_result_buffer.sv
// Result FIFO behind the multiply-add stage: buffers valido results, drains them over
// valid/ready, and counts results that arrive while the buffer is full.
module mac_result_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int DROPW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validi,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_ovf,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROPW-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;

  logic pop, push, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign out_valid = !empty;
  assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = validi && (!full || pop);
  assign drop = validi && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    // A drop in the same cycle as a clear leaves a count of one.
    if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_cnt_d)) drop_cnt_d = drop_cnt_d + DROPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_mac_result_buffer.sv
// Self-checking bench for mac_result_buffer: directed steps plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_mac_result_buffer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int DROPW = 2;
  localparam int MAXDROP = (1 << DROPW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             validi = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             clr_ovf = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic [$clog2(DEPTH):0] count;
  logic             full, empty, overflow;
  logic [DROPW-1:0] drop_cnt;

  mac_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROPW(DROPW)) dut (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .clr_ovf(clr_ovf),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus the sticky flag and drop tally.
  logic [WIDTH-1:0] modelQ[$];
  bit               modelOvf = 0;
  int               modelDrop = 0;
  logic [WIDTH-1:0] delivered[$];

  task automatic checkVal(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = modelQ.size();
    checkVal({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(n > 0));
    checkVal({tag, ".data_out"},  data_out, (n > 0) ? modelQ[0] : '0);
    checkVal({tag, ".count"},     WIDTH'(count), WIDTH'(n));
    checkVal({tag, ".full"},      WIDTH'(full), WIDTH'(n == DEPTH));
    checkVal({tag, ".empty"},     WIDTH'(empty), WIDTH'(n == 0));
    checkVal({tag, ".overflow"},  WIDTH'(overflow), WIDTH'(modelOvf));
    checkVal({tag, ".drop_cnt"},  WIDTH'(drop_cnt), WIDTH'(modelDrop));
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; validi = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; data_in = '0;
    @(posedge clk);
    modelQ.delete();
    modelOvf = 0;
    modelDrop = 0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset");
  endtask

  // One clock: drive inputs, advance the model by the handshake rules, check outputs.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
    bit doPop, doPush, doDrop;
    @(negedge clk);
    validi = v; data_in = d; out_ready = r; clr_ovf = c;
    @(posedge clk);
    doPop  = (modelQ.size() > 0) && r;
    doPush = v && ((modelQ.size() < DEPTH) || doPop);
    doDrop = v && (modelQ.size() == DEPTH) && !doPop;
    if (doPop) delivered.push_back(modelQ.pop_front());
    if (doPush) modelQ.push_back(d);
    if (c) begin
      modelOvf = 0;
      modelDrop = 0;
    end
    if (doDrop) begin
      modelOvf = 1;
      modelDrop = (modelDrop + 1 > MAXDROP) ? MAXDROP : modelDrop + 1;
    end
    #1;
    checkOutput("step");
  endtask

  initial begin
    int cyc;
    int sent;
    logic [WIDTH-1:0] sentVals[$];

    applyReset();

    // Single result, one-cycle latency, then drain.
    applyStimulus(1, 32'h7, 0, 0);
    checkVal("single.data", data_out, 32'h7);
    checkVal("single.count", WIDTH'(count), 32'd1);
    applyStimulus(0, 0, 1, 0);
    checkVal("single.empty", WIDTH'(empty), 32'd1);
    checkVal("single.zero", data_out, 32'h0);

    // Fill, two drops, drain in order.
    for (int i = 1; i <= 8; i++) applyStimulus(1, WIDTH'(i), 0, 0);
    checkVal("fill.full", WIDTH'(full), 32'd1);
    applyStimulus(1, 32'd9, 0, 0);
    applyStimulus(1, 32'd10, 0, 0);
    checkVal("ovf.flag", WIDTH'(overflow), 32'd1);
    checkVal("ovf.cnt", WIDTH'(drop_cnt), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      checkVal("drain.order", data_out, WIDTH'(i));
      applyStimulus(0, 0, 1, 0);
    end
    checkVal("drain.empty", WIDTH'(empty), 32'd1);
    applyStimulus(0, 0, 0, 1);
    checkVal("clr.ovf", WIDTH'(overflow), 32'd0);

    // Full buffer with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) applyStimulus(1, WIDTH'(i), 0, 0);
    applyStimulus(1, 32'h55, 1, 0);
    checkVal("swap.count", WIDTH'(count), 32'd8);
    checkVal("swap.nodrop", WIDTH'(drop_cnt), 32'd0);
    for (int i = 2; i <= 8; i++) applyStimulus(0, 0, 1, 0);
    checkVal("swap.last", data_out, 32'h55);
    applyStimulus(0, 0, 1, 0);

    // Wrap-around stream of 20 random results with toggling ready.
    delivered.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 20 || !empty) && cyc < 200) begin
      bit v;
      logic [WIDTH-1:0] d;
      v = (sent < 20) && (cyc % 2 == 1);
      d = $urandom;
      if (v) begin
        sentVals.push_back(d);
        sent++;
      end
      applyStimulus(v, d, (cyc % 2 == 0), 0);
      cyc++;
    end
    checkVal("wrap.budget", WIDTH'(cyc < 200), 32'd1);
    checkVal("wrap.count", WIDTH'(delivered.size()), 32'd20);
    for (int i = 0; i < 20 && i < delivered.size(); i++)
      checkVal("wrap.order", delivered[i], sentVals[i]);
    checkVal("wrap.noovf", WIDTH'(overflow), 32'd0);

    // Random traffic including occasional clears.
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0);

    // Saturation, clear coinciding with a drop, then a plain clear.
    applyReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1, WIDTH'(i), 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, $urandom, 0, 0);
    checkVal("sat.cnt", WIDTH'(drop_cnt), 32'd3);
    checkVal("sat.ovf", WIDTH'(overflow), 32'd1);
    applyStimulus(1, 32'hAA, 0, 1);
    checkVal("clrdrop.cnt", WIDTH'(drop_cnt), 32'd1);
    checkVal("clrdrop.ovf", WIDTH'(overflow), 32'd1);
    applyStimulus(0, 0, 0, 1);
    checkVal("clr.cnt", WIDTH'(drop_cnt), 32'd0);
    checkVal("clr.ovf2", WIDTH'(overflow), 32'd0);

    // Reset with entries stored discards them.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, WIDTH'(32'hC0 + i), 0, 0);
    applyReset();
    checkVal("rst.count", WIDTH'(count), 32'd0);
    checkVal("rst.data", data_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
